// File: rtl/poly_eta_pack_pkg.sv
// Shared constants, state encoding and field-width helper for the polyeta_pack block.
package poly_eta_pack_pkg;

  localparam int N          = 256;
  localparam int COEFF_W    = 32;
  localparam int IN_W       = N * COEFF_W;
  localparam int OUT_W      = 1024;
  localparam int ETA_SMALL  = 2;
  localparam int ETA_LARGE  = 4;
  localparam int BYTES_ETA2 = 96;
  localparam int BYTES_ETA4 = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PACK = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Packed field width: 3 bits covers [0,4] for ETA=2, 4 bits covers [0,8] for ETA=4.
  function automatic int field_w(input int eta);
    if (eta == ETA_LARGE) begin
      return 4;
    end else begin
      return 3;
    end
  endfunction

endpackage

// File: rtl/poly_eta_pack_if.sv
// Request/result bundle between the sampler-side requester and poly_eta_pack.
interface poly_eta_pack_if;
  import poly_eta_pack_pkg::*;

  logic             start;
  logic [IN_W-1:0]  a_in;
  logic [OUT_W-1:0] packed_out;
  logic             range_err;
  logic             done;

  modport master (output start, a_in, input packed_out, range_err, done);
  modport slave  (input start, a_in, output packed_out, range_err, done);

endinterface

// File: rtl/poly_eta_pack_coeff.sv
// One coefficient to one packed field: t = ETA - a truncated to W bits, plus range flag.
module eta_coeff_pack
  import poly_eta_pack_pkg::*;
#(
  parameter int ETA = 2
) (
  input  logic signed [COEFF_W-1:0]      coeff,
  output logic        [field_w(ETA)-1:0] field,
  output logic                           err
);

  localparam int W = field_w(ETA);
  localparam logic signed [COEFF_W-1:0] ETA_POS = COEFF_W'(ETA);
  localparam logic signed [COEFF_W-1:0] ETA_NEG = -ETA_POS;
  localparam logic        [W-1:0]       ETA_LOW = W'(ETA);

  // Only the low W bits of the difference survive, so subtract at field width.
  assign field = ETA_LOW - coeff[W-1:0];
  assign err   = (coeff > ETA_POS) || (coeff < ETA_NEG);

endmodule

// File: rtl/poly_eta_pack.sv
// Sequential polyeta_pack: captures a 256-coeff polynomial, packs COEFFS_PER_CYCLE fields per
// clock into a 1024-bit byte string, flags out-of-range coefficients.
module poly_eta_pack
  import poly_eta_pack_pkg::*;
#(
  parameter int ETA              = 2,
  parameter int COEFFS_PER_CYCLE = 8
) (
  input  logic           clock,
  input  logic           reset,
  poly_eta_pack_if.slave bus
);

  localparam int W         = field_w(ETA);
  localparam int CPC       = COEFFS_PER_CYCLE;
  localparam int LANE_BITS = W * CPC;
  localparam int IDX_W     = 8;
  localparam int BASE_W    = $clog2(OUT_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - CPC);
  localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(CPC);

  if (!(ETA == ETA_SMALL || ETA == ETA_LARGE)) begin : g_bad_eta
    $error("poly_eta_pack: ETA must be 2 or 4");
  end
  if ((CPC < 1) || ((N % CPC) != 0)) begin : g_bad_cpc
    $error("poly_eta_pack: COEFFS_PER_CYCLE must divide 256");
  end

  state_t             state_r;
  state_t             state_nx_s;
  logic [IDX_W-1:0]   idx_r;
  logic [IN_W-1:0]    a_r;
  logic [OUT_W-1:0]   packed_r;
  logic               range_err_r;
  logic               done_r;
  logic [LANE_BITS-1:0] fields_s;
  logic [CPC-1:0]     errs_s;
  logic [BASE_W-1:0]  base_s;

  // The capture register shifts down each PACK cycle, so lane k always sees coeff idx+k.
  for (genvar k = 0; k < CPC; k++) begin : g_lane
    eta_coeff_pack #(.ETA(ETA)) u_lane (
      .coeff (a_r[COEFF_W*k +: COEFF_W]),
      .field (fields_s[W*k +: W]),
      .err   (errs_s[k])
    );
  end

  assign base_s = BASE_W'(idx_r) * BASE_W'(W);

  // Next-state logic for IDLE -> LOAD -> PACK -> DONE -> IDLE.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nx_s = ST_LOAD;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD: state_nx_s = ST_PACK;
      ST_PACK: begin
        if (idx_r == LAST_IDX) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_PACK;
        end
      end
      ST_DONE: begin
        if (!bus.start) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, capture, index and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      idx_r       <= '0;
      a_r         <= '0;
      packed_r    <= '0;
      range_err_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      done_r  <= (state_nx_s == ST_DONE);
      case (state_r)
        ST_LOAD: begin
          a_r         <= bus.a_in;
          idx_r       <= '0;
          packed_r    <= '0;
          range_err_r <= 1'b0;
        end
        ST_PACK: begin
          packed_r[base_s +: LANE_BITS] <= fields_s;
          range_err_r <= range_err_r | (|errs_s);
          idx_r       <= idx_r + IDX_STEP;
          a_r         <= a_r >> (COEFF_W * CPC);
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  assign bus.packed_out = packed_r;
  assign bus.range_err  = range_err_r;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_poly_eta_pack.sv
// Directed + randomized bench for poly_eta_pack (ETA=2 and ETA=4 instances) against a
// plain-arithmetic polyeta_pack/unpack reference.
module tb_poly_eta_pack;
  import poly_eta_pack_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  poly_eta_pack_if bus2 ();
  poly_eta_pack_if bus4 ();

  poly_eta_pack #(.ETA(2), .COEFFS_PER_CYCLE(8)) dut2 (.clock(clock), .reset(reset), .bus(bus2));
  poly_eta_pack #(.ETA(4), .COEFFS_PER_CYCLE(8)) dut4 (.clock(clock), .reset(reset), .bus(bus4));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [8191:0] const_poly(input int c);
    logic [8191:0] r;
    for (int i = 0; i < 256; i++) r[32*i +: 32] = 32'(c);
    return r;
  endfunction

  function automatic logic [8191:0] rand_poly(input int eta);
    logic [8191:0] r;
    for (int i = 0; i < 256; i++) r[32*i +: 32] = 32'(int'($urandom_range(2*eta, 0)) - eta);
    return r;
  endfunction

  function automatic logic [8191:0] garbage_poly();
    logic [8191:0] r;
    for (int i = 0; i < 256; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // Reference: field i holds the low W bits of (eta - a_i), LSB-first.
  function automatic logic [1023:0] ref_pack(input int eta, input logic [8191:0] a);
    logic [1023:0] r;
    int w;
    int t;
    r = '0;
    w = (eta == 4) ? 4 : 3;
    for (int i = 0; i < 256; i++) begin
      t = eta - int'($signed(a[32*i +: 32]));
      for (int b = 0; b < w; b++) r[w*i + b] = t[b];
    end
    return r;
  endfunction

  function automatic logic ref_err(input int eta, input logic [8191:0] a);
    int c;
    for (int i = 0; i < 256; i++) begin
      c = int'($signed(a[32*i +: 32]));
      if (c > eta || c < -eta) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Golden unpack: count coefficients that do not reconstruct as eta - field.
  function automatic int unpack_mismatches(input int eta, input logic [1023:0] pk,
                                           input logic [8191:0] a);
    int w;
    int f;
    int n;
    n = 0;
    w = (eta == 4) ? 4 : 3;
    for (int i = 0; i < 256; i++) begin
      f = 0;
      for (int b = 0; b < w; b++) f[b] = pk[w*i + b];
      if ((eta - f) != int'($signed(a[32*i +: 32]))) n++;
    end
    return n;
  endfunction

  function automatic logic [1023:0] byte_pattern(input logic [7:0] b0, input logic [7:0] b1,
                                                 input logic [7:0] b2, input int nbytes);
    logic [1023:0] r;
    r = '0;
    for (int j = 0; j < nbytes; j++) begin
      case (j % 3)
        0:       r[8*j +: 8] = b0;
        1:       r[8*j +: 8] = b1;
        default: r[8*j +: 8] = b2;
      endcase
    end
    return r;
  endfunction

  task automatic set_in(input int sel, input logic st, input logic [8191:0] a);
    if (sel == 4) begin
      bus4.start = st;
      bus4.a_in  = a;
    end else begin
      bus2.start = st;
      bus2.a_in  = a;
    end
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 4) ? bus4.done : bus2.done;
  endfunction

  function automatic logic get_err(input int sel);
    return (sel == 4) ? bus4.range_err : bus2.range_err;
  endfunction

  function automatic logic [1023:0] get_pk(input int sel);
    return (sel == 4) ? bus4.packed_out : bus2.packed_out;
  endfunction

  // lat = rising edges from (and including) the one that samples start until done is seen; -1 on timeout.
  task automatic run_op(input int sel, input logic [8191:0] a, input bit drop, output int lat);
    int  edges;
    bit  seen;
    @(negedge clock);
    set_in(sel, 1'b1, a);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 100) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      if (edges == 2) set_in(sel, drop ? 1'b0 : 1'b1, garbage_poly());
      if (get_done(sel)) seen = 1'b1;
    end
    lat = seen ? edges : -1;
  endtask

  task automatic end_op(input int sel, input string tag);
    set_in(sel, 1'b0, '0);
    @(negedge clock);
    chk(tag, 1024'(get_done(sel)), 1024'(0));
  endtask

  task automatic full_check(input int sel, input logic [8191:0] a, input string tag);
    int lat;
    run_op(sel, a, 1'b0, lat);
    chk({tag, "_lat"}, 1024'(lat), 1024'(34));
    chk({tag, "_pk"}, get_pk(sel), ref_pack(sel, a));
    chk({tag, "_err"}, 1024'(get_err(sel)), 1024'(ref_err(sel, a)));
    end_op(sel, {tag, "_done_drop"});
  endtask

  initial begin
    logic [8191:0] a;
    logic [1023:0] pk;
    logic [7:0]    b;
    logic [2:0]    f;
    int            lat;

    set_in(2, 1'b0, '0);
    set_in(4, 1'b0, '0);
    #12;
    chk("rst_done2", 1024'(bus2.done), 1024'(0));
    chk("rst_err2", 1024'(bus2.range_err), 1024'(0));
    chk("rst_pk2", bus2.packed_out, '0);
    chk("rst_pk4", bus4.packed_out, '0);
    @(negedge clock);
    reset = 1'b1;

    // ETA=2 zeros: 92 24 49 repeating, upper bits zero, done on the 34th edge.
    a = const_poly(0);
    run_op(2, a, 1'b0, lat);
    chk("t1_lat", 1024'(lat), 1024'(34));
    chk("t1_bytes", bus2.packed_out, byte_pattern(8'h92, 8'h24, 8'h49, BYTES_ETA2));
    chk("t1_model", bus2.packed_out, ref_pack(2, a));
    chk("t1_err", 1024'(bus2.range_err), 1024'(0));
    end_op(2, "t1_done_drop");

    // ETA=4 constant polynomials.
    run_op(4, const_poly(0), 1'b0, lat);
    chk("t2_zero", bus4.packed_out, {128{8'h44}});
    end_op(4, "t2a_done_drop");
    run_op(4, const_poly(-4), 1'b0, lat);
    chk("t2_neg4", bus4.packed_out, {128{8'h88}});
    end_op(4, "t2b_done_drop");
    run_op(4, const_poly(4), 1'b0, lat);
    chk("t2_pos4", bus4.packed_out, '0);
    chk("t2_lat", 1024'(lat), 1024'(34));
    end_op(4, "t2c_done_drop");

    // ETA=2 -2 pattern and single +1 in coeff 0.
    run_op(2, const_poly(-2), 1'b0, lat);
    chk("t3_neg2", bus2.packed_out, byte_pattern(8'h24, 8'h49, 8'h92, BYTES_ETA2));
    end_op(2, "t3a_done_drop");
    a = const_poly(0);
    a[31:0] = 32'd1;
    run_op(2, a, 1'b0, lat);
    pk = bus2.packed_out;
    b  = pk[7:0];
    chk("t3_byte0", 1024'(b), 1024'(8'h91));
    chk("t3_model", pk, ref_pack(2, a));
    end_op(2, "t3b_done_drop");

    // Out-of-range coefficient 17 = 3: sticky flag, field 111, timing unchanged.
    a = const_poly(0);
    a[32*17 +: 32] = 32'd3;
    run_op(2, a, 1'b0, lat);
    pk = bus2.packed_out;
    f  = pk[51 +: 3];
    chk("t4_lat", 1024'(lat), 1024'(34));
    chk("t4_err", 1024'(bus2.range_err), 1024'(1));
    chk("t4_field17", 1024'(f), 1024'(3'b111));
    chk("t4_model", pk, ref_pack(2, a));
    end_op(2, "t4_done_drop");
    full_check(2, rand_poly(2), "t4_clean");

    // Random out-of-range entries on the ETA=4 instance.
    a = rand_poly(4);
    a[32*($urandom_range(255, 0)) +: 32] = $urandom() | 32'h0000_0100;
    a[32*($urandom_range(255, 0)) +: 32] = 32'hFFFF_FFFB;
    full_check(4, a, "oor4");

    // start dropped mid-PACK: operation still completes; done pulses once.
    a = rand_poly(2);
    run_op(2, a, 1'b1, lat);
    chk("drop_lat", 1024'(lat), 1024'(34));
    chk("drop_model", bus2.packed_out, ref_pack(2, a));
    @(negedge clock);
    chk("drop_done_fall", 1024'(bus2.done), 1024'(0));

    // Reset during PACK cycle 10: everything clears at once, then a clean rerun.
    @(negedge clock);
    set_in(2, 1'b1, const_poly(0));
    repeat (12) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("t5_done", 1024'(bus2.done), 1024'(0));
    chk("t5_pk", bus2.packed_out, '0);
    chk("t5_err", 1024'(bus2.range_err), 1024'(0));
    set_in(2, 1'b0, '0);
    @(negedge clock);
    reset = 1'b1;
    run_op(2, const_poly(0), 1'b0, lat);
    chk("t5_rerun_lat", 1024'(lat), 1024'(34));
    chk("t5_rerun", bus2.packed_out, byte_pattern(8'h92, 8'h24, 8'h49, BYTES_ETA2));
    end_op(2, "t5_done_drop");

    // Round trip through the golden unpack, and start held high after done.
    for (int r = 0; r < 3; r++) begin
      for (int s = 2; s <= 4; s += 2) begin
        a = rand_poly(s);
        run_op(s, a, 1'b0, lat);
        pk = get_pk(s);
        chk("rt_lat", 1024'(lat), 1024'(34));
        chk("rt_unpack", 1024'(unpack_mismatches(s, pk, a)), 1024'(0));
        chk("rt_err", 1024'(get_err(s)), 1024'(0));
        repeat (5) @(negedge clock);
        chk("rt_hold_done", 1024'(get_done(s)), 1024'(1));
        chk("rt_hold_pk", get_pk(s), pk);
        end_op(s, "rt_done_drop");
        repeat (3) @(negedge clock);
        chk("rt_no_rerun", 1024'(get_done(s)), 1024'(0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
